// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state encoding and PC arithmetic constants.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with synchronous reset and load enable.
// Reset loads RESET_PC; otherwise the value changes only when i_ld is high.
module fetch_unit_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ld,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    logic [31:0] r_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_ld) begin
            r_pc <= i_d;
        end
    end

    assign o_q = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, stall hold buffer,
// and drain of a stale request after a branch redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pc_write,
    input  logic        i_pc_src,
    input  logic [31:0] i_branch_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_ifid_pc_in,
    output logic [31:0] o_ifid_instr_in,
    output logic        o_ifid_write,
    output logic        o_if_flush
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_hold_buf;
    logic [31:0]  r_drain_addr;
    logic [31:0]  w_pc;
    logic [31:0]  w_pc_inc;
    logic [31:0]  w_pc_d;
    logic         w_pc_ld;
    logic         w_hold_ld;
    logic         w_drain_ld;

    assign w_pc_inc = w_pc + PC_INC;

    fetch_unit_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_ld (w_pc_ld),
        .i_d  (w_pc_d),
        .o_q  (w_pc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_FETCH;
            r_hold_buf   <= NOP_INSTR;
            r_drain_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_hold_ld) begin
                r_hold_buf <= i_imem_data;
            end
            if (w_drain_ld) begin
                r_drain_addr <= w_pc;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_ld         = 1'b0;
        w_pc_d          = w_pc_inc;
        w_hold_ld       = 1'b0;
        w_drain_ld      = 1'b0;
        o_imem_req      = 1'b0;
        o_imem_addr     = w_pc;
        o_ifid_write    = 1'b0;
        o_if_flush      = 1'b0;
        o_ifid_pc_in    = w_pc_inc;
        o_ifid_instr_in = i_imem_data;

        unique case (r_state)
            S_FETCH: begin
                o_imem_req = 1'b1;
                if (i_pc_src) begin
                    o_if_flush = 1'b1;
                    w_pc_ld    = 1'b1;
                    w_pc_d     = i_branch_target;
                    if (!i_imem_ready) begin
                        w_drain_ld   = 1'b1;
                        w_state_next = S_DRAIN;
                    end
                end else if (i_imem_ready) begin
                    if (i_pc_write) begin
                        o_ifid_write = 1'b1;
                        w_pc_ld      = 1'b1;
                    end else begin
                        w_hold_ld    = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end else begin
                    // Never flush a stalled decode just because memory is slow
                    o_if_flush = i_pc_write;
                end
            end
            S_HOLD: begin
                o_ifid_instr_in = r_hold_buf;
                if (i_pc_src) begin
                    o_if_flush   = 1'b1;
                    w_pc_ld      = 1'b1;
                    w_pc_d       = i_branch_target;
                    w_state_next = S_FETCH;
                end else if (i_pc_write) begin
                    o_ifid_write = 1'b1;
                    w_pc_ld      = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_DRAIN: begin
                o_imem_req  = 1'b1;
                o_imem_addr = r_drain_addr;
                if (i_pc_src) begin
                    o_if_flush = 1'b1;
                    w_pc_ld    = 1'b1;
                    w_pc_d     = i_branch_target;
                end else begin
                    o_if_flush = i_pc_write;
                end
                if (i_imem_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        if (i_rst) begin
            o_imem_req      = 1'b0;
            o_ifid_write    = 1'b0;
            o_if_flush      = 1'b1;
            o_ifid_pc_in    = '0;
            o_ifid_instr_in = NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a spec-level reference model
// checked every cycle, plus literal pins on key scenario values.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        pc_src;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        ifid_write;
    logic        if_flush;

    int n_chk = 0;
    int n_bad = 0;

    // Model state: what the fetch stage must remember, in spec terms
    logic [31:0] m_pc;
    bit          m_held;
    logic [31:0] m_held_word;
    bit          m_drain;
    logic [31:0] m_stale;

    // Outputs captured at the sampling point of the last step
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_write;
    logic        s_flush;
    logic [31:0] s_pcin;
    logic [31:0] s_instr;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_data = mem(imem_addr);

    fetch_unit #(
        .RESET_PC(RST_PC)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pc_write     (pc_write),
        .i_pc_src       (pc_src),
        .i_branch_target(target),
        .o_imem_req     (imem_req),
        .o_imem_addr    (imem_addr),
        .i_imem_ready   (imem_ready),
        .i_imem_data    (imem_data),
        .o_ifid_pc_in   (pc_in),
        .o_ifid_instr_in(instr_in),
        .o_ifid_write   (ifid_write),
        .o_if_flush     (if_flush)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit pw, input bit ps,
                        input logic [31:0] tg, input bit rdy);
        bit          e_req;
        bit          e_write;
        bit          e_flush;
        logic [31:0] e_addr;
        logic [31:0] e_word;

        rst        = r;
        pc_write   = pw;
        pc_src     = ps;
        target     = tg;
        imem_ready = rdy;
        @(negedge clk);

        e_addr  = m_drain ? m_stale : m_pc;
        e_word  = m_held ? m_held_word : mem(m_pc);
        e_req   = !r && !m_held;
        e_write = 1'b0;
        e_flush = 1'b0;
        if (r) begin
            e_flush = 1'b1;
        end else if (ps) begin
            e_flush = 1'b1;
        end else if (m_held) begin
            e_write = pw;
        end else if (m_drain) begin
            e_flush = pw;
        end else if (rdy) begin
            e_write = pw;
        end else begin
            e_flush = pw;
        end

        s_req   = imem_req;
        s_addr  = imem_addr;
        s_write = ifid_write;
        s_flush = if_flush;
        s_pcin  = pc_in;
        s_instr = instr_in;

        chk("imem_req", {31'b0, s_req}, {31'b0, e_req});
        chk("ifid_write", {31'b0, s_write}, {31'b0, e_write});
        chk("if_flush", {31'b0, s_flush}, {31'b0, e_flush});
        if (e_req) chk("imem_addr", s_addr, e_addr);
        if (r) begin
            chk("rst_pc_in", s_pcin, 32'h0);
            chk("rst_instr", s_instr, 32'h0);
        end else if (e_write) begin
            chk("pc_in", s_pcin, m_pc + 32'd4);
            chk("instr_in", s_instr, e_word);
        end

        if (r) begin
            m_pc    = RST_PC;
            m_held  = 0;
            m_drain = 0;
        end else if (ps) begin
            if (!m_held && !rdy) begin
                if (!m_drain) m_stale = m_pc;
                m_drain = 1;
            end else begin
                m_drain = 0;
            end
            m_held = 0;
            m_pc   = tg;
        end else if (m_held) begin
            if (pw) begin
                m_pc   = m_pc + 32'd4;
                m_held = 0;
            end
        end else if (m_drain) begin
            if (rdy) m_drain = 0;
        end else if (rdy) begin
            if (pw) begin
                m_pc = m_pc + 32'd4;
            end else begin
                m_held      = 1;
                m_held_word = mem(m_pc);
            end
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        m_pc    = 32'hDEAD_BEEF;
        m_held  = 0;
        m_drain = 0;
        m_stale = '0;
        m_held_word = '0;

        // Reset behaviour
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        chk("lit_rst_flush", {31'b0, s_flush}, 32'd1);
        chk("lit_rst_req", {31'b0, s_req}, 32'd0);

        // Streaming fetch, one per cycle
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 1);
            chk("lit_stream_addr", s_addr, 32'(i * 4));
            chk("lit_stream_pcin", s_pcin, 32'(i * 4 + 4));
        end

        // Memory wait at 0x10
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            chk("lit_wait_addr", s_addr, 32'h10);
        end
        step(0, 1, 0, 0, 1);
        chk("lit_wait_pcin", s_pcin, 32'h14);
        chk("lit_wait_instr", s_instr, 32'hC0DE_0010);

        // Decode stall at 0x14: hold the word
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("lit_hold_req", {31'b0, s_req}, 32'd0);
        chk("lit_hold_flush", {31'b0, s_flush}, 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("lit_hold_instr", s_instr, 32'hC0DE_0014);
        chk("lit_hold_pcin", s_pcin, 32'h18);
        step(0, 1, 0, 0, 1);
        chk("lit_after_hold", s_addr, 32'h18);
        step(0, 1, 0, 0, 1);

        // Redirect while request to 0x20 outstanding
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 32'h100, 0);
        step(0, 1, 0, 0, 0);
        chk("lit_drain_addr", s_addr, 32'h20);
        step(0, 1, 0, 0, 1);
        chk("lit_drain_discard", {31'b0, s_write}, 32'd0);
        step(0, 1, 0, 0, 1);
        chk("lit_target_addr", s_addr, 32'h100);
        chk("lit_target_pcin", s_pcin, 32'h104);

        // Second redirect during drain wins
        step(0, 1, 1, 32'h200, 0);
        step(0, 1, 1, 32'h300, 0);
        step(0, 0, 0, 0, 0);
        chk("lit_drain_stall_flush", {31'b0, s_flush}, 32'd0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        chk("lit_newer_target", s_addr, 32'h300);

        // Redirect with decode stalled
        step(0, 0, 1, 32'h400, 1);
        step(0, 1, 0, 0, 1);
        chk("lit_stall_redirect", s_addr, 32'h400);

        // Redirect out of HOLD
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h500, 0);
        step(0, 1, 0, 0, 1);
        chk("lit_hold_redirect", s_addr, 32'h500);

        // PC wrap
        step(0, 1, 1, 32'hFFFF_FFFC, 1);
        step(0, 1, 0, 0, 1);
        chk("lit_wrap_pcin", s_pcin, 32'h0);
        step(0, 1, 0, 0, 1);
        chk("lit_wrap_addr", s_addr, 32'h0);

        // Low PC bits are preserved
        step(0, 1, 1, 32'h202, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        chk("lit_lowbits", s_addr, 32'h206);

        // Reset in the middle of a drain
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 32'h700, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        chk("lit_rst_drain_addr", s_addr, 32'h0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
